drac_tile_reset_seq: RTL

DRAC_TILE_RESET_SEQ -- requirements
Module: drac_tile_reset_seq

---
 rtl/drac_pkg.sv | 27 ++
 rtl/drac_tile_reset_seq_if.sv | 40 ++++
 rtl/drac_rst_stage_cnt.sv | 46 ++++
 rtl/drac_tile_reset_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/drac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : drac_pkg
//  Description : Shared types and default constants for the DRAC tile reset
//                sequencer: FSM state encoding and default parameter values.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package drac_pkg;

    // Default parameter values for the sequencer and its interface
    localparam int unsigned c_DEF_NUM_DOMAINS   = 3;
    localparam int unsigned c_DEF_WAKE_CNT_W    = 16;
    localparam int unsigned c_DEF_STAGE_GAP     = 4;
    localparam int unsigned c_DEF_DRAIN_TIMEOUT = 1024;

    // Sequencer state encoding
    typedef enum logic [2:0] {
        ST_WAKE    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_ASSERT  = 3'd4
    } drac_state_e;

endpackage : drac_pkg
`default_nettype wire

// File: rtl/drac_tile_reset_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : drac_tile_reset_seq_if
//  Description : Control bundle between the tile and the reset sequencer.
//  Signals     : soft_rst_req_i  soft-reset request pulse (tile -> seq)
//                idle_i          per-domain quiescence flags (tile -> seq)
//                rst_n_o         per-domain active-low resets (seq -> tile)
//                soft_rst_ack_o  soft-reset assertion complete pulse
//                timeout_o       drain forced by timeout pulse
//  Modports    : master = tile side, slave = sequencer side
//  Revision    : 1.0  initial release
// ============================================================================
interface drac_tile_reset_seq_if
    import drac_pkg::*;
#(
    parameter int unsigned NumDomains = c_DEF_NUM_DOMAINS
);
    logic                  soft_rst_req_i;
    logic [NumDomains-1:0] idle_i;
    logic [NumDomains-1:0] rst_n_o;
    logic                  soft_rst_ack_o;
    logic                  timeout_o;

    modport master (
        output soft_rst_req_i,
        output idle_i,
        input  rst_n_o,
        input  soft_rst_ack_o,
        input  timeout_o
    );

    modport slave (
        input  soft_rst_req_i,
        input  idle_i,
        output rst_n_o,
        output soft_rst_ack_o,
        output timeout_o
    );
endinterface : drac_tile_reset_seq_if
`default_nettype wire

// File: rtl/drac_rst_stage_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : drac_rst_stage_cnt
//  Description : Loadable down-counter timing the gap between domain releases
//                and the soft-reset hold time. Stops at zero.
//  Ports       : clk_i       clock
//                reset_l     asynchronous active-low reset
//                i_load      load i_load_val (has priority over i_dec)
//                i_load_val  value to load
//                i_dec       decrement by one while non-zero
//                o_cnt       current count
//                o_zero      count is zero
//  Revision    : 1.0  initial release
// ============================================================================
module drac_rst_stage_cnt #(
    parameter int unsigned Width = 2
) (
    input  wire logic             clk_i,
    input  wire logic             reset_l,
    input  wire logic             i_load,
    input  wire logic [Width-1:0] i_load_val,
    input  wire logic             i_dec,
    output logic      [Width-1:0] o_cnt,
    output logic                  o_zero
);

    logic [Width-1:0] r_cnt;
    logic             w_zero;

    assign w_zero = (r_cnt == '0);

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && !w_zero) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = w_zero;

endmodule : drac_rst_stage_cnt
`default_nettype wire

// File: rtl/drac_tile_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module      : drac_tile_reset_seq
//  Description : Tile reset sequencer. After reset_l deasserts it waits a
//                wake-up period, then releases the reset domains one at a time
//                StageGap cycles apart. A soft-reset request drains the tile
//                (waits for all domains idle), holds every domain in reset for
//                StageGap cycles, acknowledges, and re-releases the domains.
//  Ports       : clk_i        clock
//                reset_l      asynchronous active-low reset
//                bus          drac_tile_reset_seq_if.slave control bundle
//                spc_grst_l   reset_l delayed by one clock
//  Options     : DRAC_RST_TIMEOUT_EN - when defined, a drain that has not seen
//                all domains idle after DrainTimeout cycles is forced into
//                reset and timeout_o pulses. Otherwise the drain waits forever.
//  Revision    : 1.0  initial release
// ============================================================================
module drac_tile_reset_seq
    import drac_pkg::*;
#(
    parameter int unsigned NumDomains   = c_DEF_NUM_DOMAINS,
    parameter int unsigned WakeCntWidth = c_DEF_WAKE_CNT_W,
    parameter int unsigned StageGap     = c_DEF_STAGE_GAP,
    parameter int unsigned DrainTimeout = c_DEF_DRAIN_TIMEOUT
) (
    input  wire logic             clk_i,
    input  wire logic             reset_l,
    drac_tile_reset_seq_if.slave  bus,
    output logic                  spc_grst_l
);

    localparam int unsigned c_IDX_W  = (NumDomains > 1) ? $clog2(NumDomains) : 1;
    localparam int unsigned c_GAP_W  = (StageGap > 1) ? $clog2(StageGap) : 1;
    localparam logic [c_IDX_W-1:0]    c_LAST_IDX = c_IDX_W'(NumDomains - 1);
    localparam logic [c_GAP_W-1:0]    c_GAP_LOAD = c_GAP_W'(StageGap - 1);
    localparam logic [NumDomains-1:0] c_DOM0     = NumDomains'(1);
    localparam logic                  c_ACK_ON_ENTRY = (StageGap == 1);

    drac_state_e              r_state;
    drac_state_e              w_state_nxt;
    logic [WakeCntWidth-1:0]  r_wake_cnt;
    logic                     w_wake_inc;
    logic [NumDomains-1:0]    r_rst_n;
    logic [NumDomains-1:0]    w_rst_n_nxt;
    logic [c_IDX_W-1:0]       r_dom_idx;
    logic [c_IDX_W-1:0]       w_dom_idx_nxt;
    logic                     r_sticky;
    logic                     w_sticky_nxt;
    logic                     r_ack;
    logic                     w_ack_nxt;
    logic                     r_grst;
    logic                     w_gap_load;
    logic                     w_gap_dec;
    logic [c_GAP_W-1:0]       w_gap_cnt;
    logic                     w_gap_zero;

`ifdef DRAC_RST_TIMEOUT_EN
    localparam int unsigned c_DRAIN_W = (DrainTimeout > 1) ? $clog2(DrainTimeout) : 1;
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(DrainTimeout - 1);

    logic [c_DRAIN_W-1:0] r_drain_cnt;
    logic                 w_drain_clr;
    logic                 w_drain_inc;
    logic                 r_timeout;
    logic                 w_timeout_nxt;
`endif

    // Shared gap timer: release spacing and soft-reset hold time
    drac_rst_stage_cnt #(
        .Width (c_GAP_W)
    ) u_gap_cnt (
        .clk_i      (clk_i),
        .reset_l    (reset_l),
        .i_load     (w_gap_load),
        .i_load_val (c_GAP_LOAD),
        .i_dec      (w_gap_dec),
        .o_cnt      (w_gap_cnt),
        .o_zero     (w_gap_zero)
    );

    // Next-state and registered-output decode
    always_comb begin
        w_state_nxt   = r_state;
        w_rst_n_nxt   = r_rst_n;
        w_dom_idx_nxt = r_dom_idx;
        w_wake_inc    = 1'b0;
        w_gap_load    = 1'b0;
        w_gap_dec     = 1'b0;
        w_ack_nxt     = 1'b0;
        // Requests outside RUN merge into a single pending request
        w_sticky_nxt  = r_sticky | bus.soft_rst_req_i;
`ifdef DRAC_RST_TIMEOUT_EN
        w_drain_clr   = 1'b0;
        w_drain_inc   = 1'b0;
        w_timeout_nxt = 1'b0;
`endif

        case (r_state)
            ST_WAKE: begin
                // Counter saturates once its MSB is set
                if (r_wake_cnt[WakeCntWidth-1]) begin
                    w_state_nxt   = ST_RELEASE;
                    w_rst_n_nxt   = c_DOM0;
                    w_dom_idx_nxt = '0;
                    w_gap_load    = 1'b1;
                end else begin
                    w_wake_inc    = 1'b1;
                end
            end

            ST_RELEASE: begin
                if (r_dom_idx == c_LAST_IDX) begin
                    w_state_nxt = ST_RUN;
                end else if (w_gap_zero) begin
                    // Released domains form a contiguous run of ones from bit 0
                    w_rst_n_nxt   = (r_rst_n << 1) | c_DOM0;
                    w_dom_idx_nxt = r_dom_idx + 1'b1;
                    w_gap_load    = 1'b1;
                end else begin
                    w_gap_dec     = 1'b1;
                end
            end

            ST_RUN: begin
                w_sticky_nxt = 1'b0;
                if (r_sticky || bus.soft_rst_req_i) begin
                    w_state_nxt = ST_DRAIN;
`ifdef DRAC_RST_TIMEOUT_EN
                    w_drain_clr = 1'b1;
`endif
                end
            end

            ST_DRAIN: begin
                if (&bus.idle_i) begin
                    w_state_nxt = ST_ASSERT;
                    w_rst_n_nxt = '0;
                    w_gap_load  = 1'b1;
                    w_ack_nxt   = c_ACK_ON_ENTRY;
                end
`ifdef DRAC_RST_TIMEOUT_EN
                else if (r_drain_cnt == c_DRAIN_LAST) begin
                    w_state_nxt   = ST_ASSERT;
                    w_rst_n_nxt   = '0;
                    w_gap_load    = 1'b1;
                    w_ack_nxt     = c_ACK_ON_ENTRY;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_drain_inc   = 1'b1;
                end
`endif
            end

            ST_ASSERT: begin
                if (w_gap_zero) begin
                    w_state_nxt   = ST_RELEASE;
                    w_rst_n_nxt   = c_DOM0;
                    w_dom_idx_nxt = '0;
                    w_gap_load    = 1'b1;
                end else begin
                    w_gap_dec     = 1'b1;
                    // Ack is registered, so raise it as the last hold cycle begins
                    w_ack_nxt     = (w_gap_cnt == c_GAP_W'(1));
                end
            end

            default: begin
                w_state_nxt = ST_WAKE;
                w_rst_n_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            r_state    <= ST_WAKE;
            r_wake_cnt <= '0;
            r_rst_n    <= '0;
            r_dom_idx  <= '0;
            r_sticky   <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            if (w_wake_inc) begin
                r_wake_cnt <= r_wake_cnt + 1'b1;
            end
            r_rst_n    <= w_rst_n_nxt;
            r_dom_idx  <= w_dom_idx_nxt;
            r_sticky   <= w_sticky_nxt;
            r_ack      <= w_ack_nxt;
        end
    end

`ifdef DRAC_RST_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            r_drain_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (w_drain_clr) begin
                r_drain_cnt <= '0;
            end else if (w_drain_inc) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end
            r_timeout <= w_timeout_nxt;
        end
    end

    assign bus.timeout_o = r_timeout;
`else
    assign bus.timeout_o = 1'b0;
`endif

    // Registered copy of the global reset for the chip-level bench
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            r_grst <= 1'b0;
        end else begin
            r_grst <= 1'b1;
        end
    end

    assign spc_grst_l         = r_grst;
    assign bus.rst_n_o        = r_rst_n;
    assign bus.soft_rst_ack_o = r_ack;

endmodule : drac_tile_reset_seq
`default_nettype wire
